// File: rtl/axil_servo_array.sv
// axil_servo_array
//   Multi-channel AXI4-Lite servo peripheral. NUM_CH PWM servo channels share
//   one frame counter; each channel has a target angle, a slewed current angle
//   and a latched enable. Enable and angle changes take effect only at frame
//   boundaries, so pulses are never truncated or stretched mid-frame.
//
//   Register map (byte offsets from BASE_ADDR):
//     0x00 CTRL     RW  [NUM_CH-1:0] enable mask
//     0x04 STATUS   RO  [NUM_CH-1:0] ch_active
//     0x08 STEP     RW  [7:0] max degrees per frame (0 = jump)
//     0x10+4*i ANGLE_i  RW  write [7:0] target (0..180),
//                           read {16'b0, current[7:0], target[7:0]}
//
//   Ports:
//     ACLK, ARESETn         clock, asynchronous active-low reset
//     AW*/W*/B*             AXI4-Lite write address / data / response
//     AR*/R*                AXI4-Lite read address / data
//     pwm_out[NUM_CH]       registered servo pulse per channel
//     ch_active[NUM_CH]     enable mask latched at the last frame boundary
//
//   Handshakes: a transfer happens on a channel in any cycle where both VALID
//   and READY are high at the rising edge of ACLK. VALID is held with stable
//   payload until that edge; READY never depends on the same channel's VALID.
module axil_servo_array #(
  parameter logic [31:0] BASE_ADDR     = 32'h4000_0000,
  parameter int          NUM_CH        = 4,
  parameter int          PERIOD_CYC    = 1_000_000,
  parameter int          PULSE_MIN_CYC = 25_000,
  parameter int          CYC_PER_DEG   = 556
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [31:0]       AWADDR,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [2:0]        AWPROT,
  input  logic [31:0]       WDATA,
  input  logic [3:0]        WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic              BVALID,
  input  logic              BREADY,
  output logic [1:0]        BRESP,
  input  logic [31:0]       ARADDR,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [2:0]        ARPROT,
  output logic [31:0]       RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [NUM_CH-1:0] ch_active
);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("axil_servo_array: NUM_CH must be in 1..8");
  end
  if (PULSE_MIN_CYC + 180 * CYC_PER_DEG >= PERIOD_CYC) begin : g_bad_timing
    $error("axil_servo_array: maximum pulse does not fit in PWM frame");
  end

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] CH_MASK     = (32'd1 << NUM_CH) - 32'd1;
  localparam logic [31:0] LAST_CNT    = 32'(PERIOD_CYC - 1);

  // Write path state
  logic              aw_held_q, aw_held_d;
  logic [31:0]       aw_addr_q, aw_addr_d;
  logic              w_held_q,  w_held_d;
  logic [31:0]       w_data_q,  w_data_d;
  logic [3:0]        w_strb_q,  w_strb_d;
  logic              bvalid_q,  bvalid_d;
  logic [1:0]        bresp_q,   bresp_d;
  // Read path state
  logic              rvalid_q,  rvalid_d;
  logic [31:0]       rdata_q,   rdata_d;
  logic [1:0]        rresp_q,   rresp_d;
  // Registers and PWM engine
  logic [NUM_CH-1:0] ctrl_q,      ctrl_d;
  logic [7:0]        step_q,      step_d;
  logic [7:0]        target_q  [NUM_CH];
  logic [7:0]        target_d  [NUM_CH];
  logic [7:0]        current_q [NUM_CH];
  logic [7:0]        current_d [NUM_CH];
  logic [NUM_CH-1:0] ch_active_q, ch_active_d;
  logic [NUM_CH-1:0] pwm_q,       pwm_d;
  logic [31:0]       cnt_q,       cnt_d;

  logic [31:0] w_off;
  logic [31:0] ar_off;
  logic        frame_end;
  logic        unused_ok;

  assign w_off     = aw_addr_q - BASE_ADDR;
  assign ar_off    = ARADDR - BASE_ADDR;
  assign frame_end = (cnt_q == LAST_CNT);
  assign unused_ok = ^{AWPROT, ARPROT};

  assign AWREADY   = !aw_held_q && !bvalid_q;
  assign WREADY    = !w_held_q && !bvalid_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign ARREADY   = !rvalid_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign pwm_out   = pwm_q;
  assign ch_active = ch_active_q;

  // Move current one slew step toward target; STEP=0 jumps straight there.
  function automatic logic [7:0] slew(input logic [7:0] cur,
                                      input logic [7:0] tgt,
                                      input logic [7:0] step);
    logic [7:0] diff;
    diff = (tgt > cur) ? (tgt - cur) : (cur - tgt);
    if (step == 8'd0 || diff <= step) return tgt;
    else if (tgt > cur)               return cur + step;
    else                              return cur - step;
  endfunction

  // Write channel: independent AW/W holds, then one commit cycle.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    ctrl_d    = ctrl_q;
    step_d    = step_q;
    target_d  = target_q;

    if (AWVALID && AWREADY) begin
      aw_held_d = 1'b1;
      aw_addr_d = AWADDR;
    end
    if (WVALID && WREADY) begin
      w_held_d = 1'b1;
      w_data_d = WDATA;
      w_strb_d = WSTRB;
    end
    if (bvalid_q && BREADY) bvalid_d = 1'b0;

    // Both holds can only be set while BVALID is low, so the commit never
    // collides with a pending response.
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = RESP_SLVERR;
      if (w_strb_q == 4'hF && w_off[1:0] == 2'b00) begin
        if (w_off == 32'h0) begin
          if ((w_data_q & ~CH_MASK) == 32'h0) begin
            ctrl_d  = w_data_q[NUM_CH-1:0];
            bresp_d = RESP_OKAY;
          end
        end else if (w_off == 32'h8) begin
          step_d  = w_data_q[7:0];
          bresp_d = RESP_OKAY;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (w_off == 32'h10 + 32'(4 * i) && w_data_q <= 32'd180) begin
              target_d[i] = w_data_q[7:0];
              bresp_d     = RESP_OKAY;
            end
          end
        end
      end
    end
  end

  // Read channel: decode on the AR handshake, hold response until RREADY.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q && RREADY) rvalid_d = 1'b0;
    if (ARVALID && ARREADY) begin
      rvalid_d = 1'b1;
      rdata_d  = 32'h0;
      rresp_d  = RESP_SLVERR;
      if (ar_off[1:0] == 2'b00) begin
        if (ar_off == 32'h0) begin
          rdata_d = 32'(ctrl_q);
          rresp_d = RESP_OKAY;
        end else if (ar_off == 32'h4) begin
          rdata_d = 32'(ch_active_q);
          rresp_d = RESP_OKAY;
        end else if (ar_off == 32'h8) begin
          rdata_d = {24'h0, step_q};
          rresp_d = RESP_OKAY;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (ar_off == 32'h10 + 32'(4 * i)) begin
              rdata_d = {16'h0, current_q[i], target_q[i]};
              rresp_d = RESP_OKAY;
            end
          end
        end
      end
    end
  end

  // PWM engine. Register writes landing on the boundary edge are seen here
  // through the _q values, so they apply one frame later.
  always_comb begin
    cnt_d       = frame_end ? 32'h0 : cnt_q + 32'd1;
    ch_active_d = frame_end ? ctrl_q : ch_active_q;
    for (int i = 0; i < NUM_CH; i++) begin
      current_d[i] = frame_end ? slew(current_q[i], target_q[i], step_q)
                               : current_q[i];
      pwm_d[i]     = ch_active_q[i] &&
                     (cnt_q < 32'(PULSE_MIN_CYC) +
                              32'(current_q[i]) * 32'(CYC_PER_DEG));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held_q   <= 1'b0;
      aw_addr_q   <= 32'h0;
      w_held_q    <= 1'b0;
      w_data_q    <= 32'h0;
      w_strb_q    <= 4'h0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'h0;
      rresp_q     <= 2'b00;
      ctrl_q      <= '0;
      step_q      <= 8'h0;
      ch_active_q <= '0;
      pwm_q       <= '0;
      cnt_q       <= 32'h0;
      for (int i = 0; i < NUM_CH; i++) begin
        target_q[i]  <= 8'h0;
        current_q[i] <= 8'h0;
      end
    end else begin
      aw_held_q   <= aw_held_d;
      aw_addr_q   <= aw_addr_d;
      w_held_q    <= w_held_d;
      w_data_q    <= w_data_d;
      w_strb_q    <= w_strb_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      ctrl_q      <= ctrl_d;
      step_q      <= step_d;
      ch_active_q <= ch_active_d;
      pwm_q       <= pwm_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      current_q   <= current_d;
    end
  end

endmodule

// File: tb/tb_axil_servo_array.sv
// Self-checking bench for axil_servo_array with a short PWM frame
// (1000 cycles, 100 + 4*angle pulse cycles, 4 channels).
module tb_axil_servo_array;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          NCH  = 4;

  logic              ACLK;
  logic              ARESETn;
  logic [31:0]       AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [2:0]        AWPROT;
  logic [31:0]       WDATA;
  logic [3:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BRESP;
  logic [31:0]       ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [2:0]        ARPROT;
  logic [31:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;
  logic [NCH-1:0]    pwm_out;
  logic [NCH-1:0]    ch_active;

  // Scoreboard entries: {resp[1:0], data[31:0]}; data is ignored for writes.
  logic [33:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  axil_servo_array #(
    .BASE_ADDR(BASE), .NUM_CH(NCH), .PERIOD_CYC(1000),
    .PULSE_MIN_CYC(100), .CYC_PER_DEG(4)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWPROT(AWPROT),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARPROT(ARPROT),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .pwm_out(pwm_out), .ch_active(ch_active)
  );

  // ---------------- clock / reset ----------------
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic do_reset();
    ARESETn = 1'b0;
    AWADDR = '0; AWVALID = 0; AWPROT = '0; WDATA = '0; WSTRB = '0; WVALID = 0;
    BREADY = 0; ARADDR = '0; ARVALID = 0; ARPROT = '0; RREADY = 0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  // ---------------- driver tasks ----------------
  // W is presented w_lag cycles after AW; BREADY held low b_delay cycles
  // after BVALID is seen. A timed-out response returns 2'b11.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lag,
                           input int b_delay, output logic [1:0] resp,
                           output bit aw_hold_ok, output bit b_stable_ok);
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; aw_hold_ok = 1; b_stable_ok = 1;
    @(negedge ACLK);
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1;
    while (!(aw_done && w_done) && cyc < 200) begin
      if (cyc >= w_lag && !w_done) WVALID = 1;
      if (aw_done && !w_done && AWREADY) aw_hold_ok = 0;
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(negedge ACLK);
      cyc++;
      if (aw_fire) begin aw_done = 1; AWVALID = 0; end
      if (w_fire)  begin w_done  = 1; WVALID  = 0; end
    end
    AWVALID = 0; WVALID = 0;
    cyc = 0;
    while (!BVALID && cyc < 200) begin @(negedge ACLK); cyc++; end
    if (!BVALID) begin
      resp = 2'b11;
      return;
    end
    resp = BRESP;
    for (int k = 0; k < b_delay; k++) begin
      @(negedge ACLK);
      if (BVALID !== 1'b1 || BRESP !== resp) b_stable_ok = 0;
    end
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int cyc;
    cyc = 0;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1;
    while (!ARREADY && cyc < 200) begin @(negedge ACLK); cyc++; end
    @(negedge ACLK);
    ARVALID = 0;
    cyc = 0;
    while (!RVALID && cyc < 200) begin @(negedge ACLK); cyc++; end
    if (!RVALID) begin
      data = 32'hDEAD_BEEF; resp = 2'b11;
      return;
    end
    data = RDATA; resp = RRESP;
    RREADY = 1;
    @(negedge ACLK);
    RREADY = 0;
  endtask

  // Returns 1 once pwm_out[1] rises, i.e. just after a frame boundary.
  task automatic wait_frame_start(output bit found);
    logic prev;
    found = 0;
    prev = pwm_out[1];
    for (int c = 0; c < 2500 && !found; c++) begin
      @(negedge ACLK);
      if (pwm_out[1] && !prev) found = 1;
      prev = pwm_out[1];
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic [33:0] e;
    n_total++; if ({AWREADY, WREADY, ARREADY} !== 3'b111)
      $display("FAIL reset_ready actual=%b required=111", {AWREADY, WREADY, ARREADY});
    else n_pass++;
    n_total++; if ({BVALID, RVALID} !== 2'b00)
      $display("FAIL reset_valid actual=%b required=00", {BVALID, RVALID});
    else n_pass++;
    n_total++; if ({BRESP, RRESP, RDATA} !== 36'h0)
      $display("FAIL reset_resp actual=%h required=0", {BRESP, RRESP, RDATA});
    else n_pass++;
    n_total++; if ({pwm_out, ch_active} !== '0)
      $display("FAIL reset_pwm actual=%b required=0", {pwm_out, ch_active});
    else n_pass++;
    exp_q.push_back({2'b00, 32'h0});
    axi_read(BASE + 32'h4, d, r);
    e = exp_q.pop_front();
    n_total++; if ({r, d} !== e)
      $display("FAIL reset_status actual=%h required=%h", {r, d}, e);
    else n_pass++;
  endtask

  task automatic test_ch1_pwm();
    logic [31:0] addr_t[3] = '{BASE + 32'h14, BASE + 32'h8, BASE + 32'h0};
    logic [31:0] data_t[3] = '{32'd90, 32'd0, 32'h2};
    logic [31:0] d; logic [1:0] r; logic [33:0] e; bit a, s;
    int hi1, hi_oth, cyc;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'b00, 32'h0});
      axi_write(addr_t[i], data_t[i], 4'hF, 0, 0, r, a, s);
      e = exp_q.pop_front();
      n_total++; if (r !== e[33:32])
        $display("FAIL cfg_write%0d actual=%b required=%b", i, r, e[33:32]);
      else n_pass++;
    end
    cyc = 0;
    while (ch_active !== 4'b0010 && cyc < 2500) begin @(negedge ACLK); cyc++; end
    n_total++; if (ch_active !== 4'b0010)
      $display("FAIL ch_active actual=%b required=0010", ch_active);
    else n_pass++;
    hi1 = 0; hi_oth = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge ACLK);
      if (pwm_out[1]) hi1++;
      if (pwm_out[0] || pwm_out[2] || pwm_out[3]) hi_oth++;
    end
    n_total++; if (hi1 !== 460)
      $display("FAIL pwm1_width actual=%0d required=460", hi1);
    else n_pass++;
    n_total++; if (hi_oth !== 0)
      $display("FAIL pwm_other actual=%0d required=0", hi_oth);
    else n_pass++;
    exp_q.push_back({2'b00, 32'h0000_5A5A});
    axi_read(BASE + 32'h14, d, r);
    e = exp_q.pop_front();
    n_total++; if ({r, d} !== e)
      $display("FAIL angle1_read actual=%h required=%h", {r, d}, e);
    else n_pass++;
  endtask

  task automatic test_errors();
    // Writes expected to be rejected, then reads of the untouched state.
    logic [31:0] wa[5] = '{BASE + 32'h10, BASE + 32'h4, BASE + 32'h0,
                           BASE + 32'h8, BASE + 32'h9};
    logic [31:0] wd[5] = '{32'd181, 32'h1, 32'h13, 32'h5, 32'h5};
    logic [3:0]  ws[5] = '{4'hF, 4'hF, 4'hF, 4'h3, 4'hF};
    logic [31:0] ra[5] = '{BASE + 32'h10, BASE + 32'hC, BASE + 32'h0,
                           BASE + 32'h8, BASE + 32'h4};
    logic [33:0] re[5] = '{{2'b00, 32'h0}, {2'b10, 32'h0}, {2'b00, 32'h2},
                           {2'b00, 32'h0}, {2'b00, 32'h2}};
    logic [31:0] d; logic [1:0] r; logic [33:0] e; bit a, s;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({2'b10, 32'h0});
      axi_write(wa[i], wd[i], ws[i], 0, 0, r, a, s);
      e = exp_q.pop_front();
      n_total++; if (r !== e[33:32])
        $display("FAIL err_write%0d actual=%b required=%b", i, r, e[33:32]);
      else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(re[i]);
      axi_read(ra[i], d, r);
      e = exp_q.pop_front();
      n_total++; if ({r, d} !== e)
        $display("FAIL err_read%0d actual=%h required=%h", i, {r, d}, e);
      else n_pass++;
    end
  endtask

  task automatic test_slew();
    logic [7:0] cur_t[6] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd45, 8'd45};
    logic [31:0] d; logic [1:0] r; logic [33:0] e; bit a, s, found;
    exp_q.push_back({2'b00, 32'h0});
    axi_write(BASE + 32'h8, 32'd10, 4'hF, 0, 0, r, a, s);
    e = exp_q.pop_front();
    n_total++; if (r !== e[33:32])
      $display("FAIL step_write actual=%b required=%b", r, e[33:32]);
    else n_pass++;
    exp_q.push_back({2'b00, 32'h0});
    axi_write(BASE + 32'h18, 32'd45, 4'hF, 0, 0, r, a, s);
    e = exp_q.pop_front();
    n_total++; if (r !== e[33:32])
      $display("FAIL angle2_write actual=%b required=%b", r, e[33:32]);
    else n_pass++;
    for (int f = 0; f < 6; f++) begin
      wait_frame_start(found);
      n_total++; if (found !== 1'b1)
        $display("FAIL frame_start%0d actual=%b required=1", f, found);
      else n_pass++;
      exp_q.push_back({2'b00, 16'h0, cur_t[f], 8'd45});
      axi_read(BASE + 32'h18, d, r);
      e = exp_q.pop_front();
      n_total++; if ({r, d} !== e)
        $display("FAIL slew_frame%0d actual=%h required=%h", f, {r, d}, e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; logic [33:0] e; bit a, s;
    exp_q.push_back({2'b00, 32'h0});
    axi_write(BASE + 32'h8, 32'h33, 4'hF, 3, 4, r, a, s);
    e = exp_q.pop_front();
    n_total++; if (r !== e[33:32])
      $display("FAIL b2b_resp actual=%b required=%b", r, e[33:32]);
    else n_pass++;
    n_total++; if (a !== 1'b1)
      $display("FAIL b2b_awready_held actual=%b required=1", a);
    else n_pass++;
    n_total++; if (s !== 1'b1)
      $display("FAIL b2b_bresp_stable actual=%b required=1", s);
    else n_pass++;
    exp_q.push_back({2'b00, 32'h33});
    axi_read(BASE + 32'h8, d, r);
    e = exp_q.pop_front();
    n_total++; if ({r, d} !== e)
      $display("FAIL b2b_step_read actual=%h required=%h", {r, d}, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] ra[5] = '{BASE + 32'h0, BASE + 32'h4, BASE + 32'h8,
                           BASE + 32'h14, BASE + 32'h18};
    logic [31:0] d; logic [1:0] r; logic [33:0] e; int cyc;
    cyc = 0;
    while (pwm_out[1] !== 1'b1 && cyc < 2500) begin @(negedge ACLK); cyc++; end
    n_total++; if (pwm_out[1] !== 1'b1)
      $display("FAIL pre_reset_pulse actual=%b required=1", pwm_out[1]);
    else n_pass++;
    #2 ARESETn = 1'b0;
    #1;
    n_total++; if ({pwm_out, ch_active} !== '0)
      $display("FAIL async_reset_pwm actual=%b required=0", {pwm_out, ch_active});
    else n_pass++;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({2'b00, 32'h0});
      axi_read(ra[i], d, r);
      e = exp_q.pop_front();
      n_total++; if ({r, d} !== e)
        $display("FAIL post_reset_read%0d actual=%h required=%h", i, {r, d}, e);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    do_reset();
    test_reset();
    test_ch1_pwm();
    test_errors();
    test_slew();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axil_servo_array.md
Name: axil_servo_array

Overview:
- Multi-channel AXI4-Lite servo peripheral: NUM_CH independent PWM servo channels behind one slave port.
- Adds per-channel angle registers, a global enable mask, a read-only status register and programmable slew limiting (degrees per PWM frame).
- PWM generation is internal and glitch-free: enable and angle changes apply only at frame boundaries.
- Sits on the AXI-Lite peripheral bus beside the existing single-channel servo block.

Parameters:
- BASE_ADDR, 32'h4000_0000, byte base address of the register window.
- NUM_CH, 4, servo channel count, legal 1..8.
- PERIOD_CYC, 1_000_000, PWM frame length in ACLK cycles.
- PULSE_MIN_CYC, 25_000, pulse width at 0 degrees, in cycles.
- CYC_PER_DEG, 556, added pulse cycles per degree. Elaboration error unless PULSE_MIN_CYC+180*CYC_PER_DEG < PERIOD_CYC.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset
- AWADDR  in  32  write address
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address ready
- AWPROT  in  3  ignored
- WDATA  in  32  write data
- WSTRB  in  4  write strobes
- WVALID  in  1  write data valid
- WREADY  out  1  write data ready
- BVALID  out  1  write response valid
- BREADY  in  1  write response ready
- BRESP  out  2  write response
- ARADDR  in  32  read address
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address ready
- ARPROT  in  3  ignored
- RDATA  out  32  read data
- RRESP  out  2  read response
- RVALID  out  1  read data valid
- RREADY  in  1  read data ready
- pwm_out  out  NUM_CH  servo pulse per channel
- ch_active  out  NUM_CH  latched enable per channel

Behaviour:
- Reset: ARESETn asynchronous, active-low; clock ACLK; all state registers zero on reset.
  - Reset outputs: AWREADY/WREADY/ARREADY=1; BVALID/RVALID=0; BRESP/RRESP=0; RDATA=0; pwm_out/ch_active=0.
  - Reset mid-pulse forces pwm_out low immediately.
- Register map (offset from BASE_ADDR):
  - 0x00 CTRL RW: bits[NUM_CH-1:0] enable mask. Nonzero bits above NUM_CH -> SLVERR.
  - 0x04 STATUS RO: [NUM_CH-1:0]=ch_active. Write -> SLVERR.
  - 0x08 STEP RW: [7:0] max degrees per frame; 0 means immediate.
  - 0x10+4*i ANGLE_i RW, i<NUM_CH: write [7:0] target, value 0..180. Read returns {16'b0, current[15:8], target[7:0]}.
  - Anything else, unaligned (addr[1:0]!=0), or WSTRB!=4'hF -> SLVERR (2'b10), no register change. Unmapped read returns RDATA=0, RRESP=2'b10.
  - Write of value >180 to ANGLE_i -> SLVERR, register unchanged.
- Write path:
  - AW and W captured independently into one-entry holding registers, in any order or the same cycle.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - Cycle after both are held: register update, BVALID=1 with BRESP, both holds cleared.
  - BVALID held with stable BRESP until BREADY. Exactly one update per transaction.
- Read path:
  - ARREADY = !RVALID.
  - AR handshake -> RVALID with RDATA/RRESP next cycle, held stable until RREADY.
  - Read and write may proceed concurrently.
- PWM engine:
  - Shared frame counter 0..PERIOD_CYC-1, wraps to 0.
  - At the wrap (frame boundary): ch_active <= CTRL mask. Current angle steps toward target by min(STEP, |target-current|), or jumps to target if STEP=0.
  - pwm_out[i] = ch_active[i] && cnt < PULSE_MIN_CYC + current_i*CYC_PER_DEG, computed at 32-bit width, registered.
- Simultaneous events: register write in the same cycle as the boundary uses the old value; the new value applies at the next boundary. Disabled channels keep slewing current.

Test Plan (PERIOD_CYC=1000, PULSE_MIN_CYC=100, CYC_PER_DEG=4, NUM_CH=4):
- Reset and hold -> ready signals 1, BVALID/RVALID 0, pwm_out=0; read 0x04 -> 0, RRESP 00.
- Write ANGLE1=90, STEP=0, CTRL=4'b0010 -> from the next boundary ch_active=0010 and pwm_out[1] high 460 cycles per 1000-cycle frame; other channels low.
- Write ANGLE0=181 -> BRESP=10; read 0x10 -> RDATA=0. Read 0x0C -> RRESP=10, RDATA=0.
- STEP=10, ANGLE2 0->45 -> current over successive frames 10,20,30,40,45, then steady; readback [15:8] tracks it.
- AW issued 3 cycles before W, BREADY low 4 cycles -> AWREADY low while held; BVALID/BRESP stable 4 cycles; single register update.
- Assert ARESETn low mid-pulse -> pwm_out=0 same cycle; all registers read 0 after release.
